// File: rtl/quark_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : quark_lsu_pkg
// Desc     : Shared funct3 codes, FSM state type and lane helper functions
//            for the quark load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package quark_lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } lsu_state_t;

   // Halves only look at addr[1] and words at nothing, so an unaligned
   // access is silently issued aligned.
   function automatic logic [3:0] lsu_be(input logic [2:0] funct3,
                                         input logic [1:0] off);
      case (funct3)
         F3_LB, F3_LBU: lsu_be = 4'b0001 << off;
         F3_LH, F3_LHU: lsu_be = off[1] ? 4'b1100 : 4'b0011;
         default:       lsu_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lsu_replicate(input logic [2:0]  funct3,
                                                 input logic [31:0] wdata);
      case (funct3)
         F3_LB, F3_LBU: lsu_replicate = {4{wdata[7:0]}};
         F3_LH, F3_LHU: lsu_replicate = {2{wdata[15:0]}};
         default:       lsu_replicate = wdata;
      endcase
   endfunction

   function automatic logic lsu_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] off);
      case (funct3)
         F3_LB, F3_LBU: lsu_misaligned = 1'b0;
         F3_LH, F3_LHU: lsu_misaligned = off[0];
         default:       lsu_misaligned = (off != 2'b00);
      endcase
   endfunction

endpackage : quark_lsu_pkg
`default_nettype wire

// File: rtl/quark_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : quark_lsu_align
// Desc     : Combinational lane logic: byte enables and store replication for
//            the outgoing request, lane extraction and extension for loads.
// Revision : 1.0 - initial release
// ============================================================================
module quark_lsu_align
   import quark_lsu_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata_rep,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign st_be        = lsu_be(st_funct3, st_off);
   assign st_wdata_rep = lsu_replicate(st_funct3, st_wdata);

   always_comb begin
      w_byte = ld_rdata[7:0];
      case (ld_off)
         2'd0:    w_byte = ld_rdata[7:0];
         2'd1:    w_byte = ld_rdata[15:8];
         2'd2:    w_byte = ld_rdata[23:16];
         default: w_byte = ld_rdata[31:24];
      endcase
   end

   assign w_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];

   always_comb begin
      ld_data = ld_rdata;
      case (ld_funct3)
         F3_LB:   ld_data = {{24{w_byte[7]}}, w_byte};
         F3_LBU:  ld_data = {24'd0, w_byte};
         F3_LH:   ld_data = {{16{w_half[15]}}, w_half};
         F3_LHU:  ld_data = {16'd0, w_half};
         default: ld_data = ld_rdata;
      endcase
   end

endmodule : quark_lsu_align
`default_nettype wire

// File: rtl/quark_lsu.sv
`default_nettype none
// ============================================================================
// Module   : quark_lsu
// Desc     : Load/store unit between the quark core data port and a
//            req/gnt/rvalid data bus; stalls the core until completion.
// Options  : QUARK_LSU_MISALIGN_TRAP_EN - trap misaligned half/word accesses
// Revision : 1.0 - initial release
// ============================================================================
module quark_lsu
   import quark_lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [2:0]        core_funct3,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [31:0]       core_wdata,
   output logic [31:0]       core_rdata,
   output logic              core_stall,
   output logic              core_fault,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_gnt,
   input  logic              bus_rvalid,
   input  logic [31:0]       bus_rdata
);

   lsu_state_t        r_state;
   lsu_state_t        w_state_next;

   logic              r_bus_req;
   logic              r_we;
   logic [2:0]        r_funct3;
   logic [1:0]        r_off;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [3:0]        r_bus_be;
   logic [31:0]       r_bus_wdata;
   logic [31:0]       r_rdata;

   logic [3:0]        w_be;
   logic [31:0]       w_wdata_rep;
   logic [31:0]       w_ld_data;
   logic              w_start;
   logic              w_trap;

   assign w_start = (r_state == S_IDLE) && core_req;

   quark_lsu_align u_align (
      .st_funct3    (core_funct3),
      .st_off       (core_addr[1:0]),
      .st_wdata     (core_wdata),
      .st_be        (w_be),
      .st_wdata_rep (w_wdata_rep),
      .ld_funct3    (r_funct3),
      .ld_off       (r_off),
      .ld_rdata     (bus_rdata),
      .ld_data      (w_ld_data)
   );

`ifdef QUARK_LSU_MISALIGN_TRAP_EN
   logic r_fault;

   assign w_trap = w_start && lsu_misaligned(core_funct3, core_addr[1:0]);

   // Set only on the IDLE->DONE trap edge, so it is high for the DONE cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fault <= 1'b0;
      end else begin
         r_fault <= w_trap;
      end
   end

   assign core_fault = r_fault;
`else
   assign w_trap     = 1'b0;
   assign core_fault = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (core_req)   w_state_next = w_trap ? S_DONE : S_REQ;
         S_REQ:  if (bus_gnt)    w_state_next = r_we ? S_DONE : S_WAIT;
         S_WAIT: if (bus_rvalid) w_state_next = S_DONE;
         S_DONE:                 w_state_next = S_IDLE;
         default:                w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_bus_req   <= 1'b0;
         r_we        <= 1'b0;
         r_funct3    <= 3'd0;
         r_off       <= 2'd0;
         r_bus_addr  <= '0;
         r_bus_be    <= 4'd0;
         r_bus_wdata <= 32'd0;
         r_rdata     <= 32'd0;
      end else begin
         r_state   <= w_state_next;
         // Registered request follows the state, dropping right after gnt.
         r_bus_req <= (w_state_next == S_REQ);
         if (w_start) begin
            r_we        <= core_we;
            r_funct3    <= core_funct3;
            r_off       <= core_addr[1:0];
            r_bus_addr  <= {core_addr[ADDR_W-1:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata_rep;
            r_rdata     <= 32'd0;
         end
         if ((r_state == S_WAIT) && bus_rvalid) begin
            r_rdata <= w_ld_data;
         end
      end
   end

   assign core_stall = core_req && (r_state != S_DONE);
   assign core_rdata = r_rdata;
   assign bus_req    = r_bus_req;
   assign bus_we     = r_we;
   assign bus_addr   = r_bus_addr;
   assign bus_be     = r_bus_be;
   assign bus_wdata  = r_bus_wdata;

endmodule : quark_lsu
`default_nettype wire

// File: tb/tb_quark_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_quark_lsu
// Desc     : Self-checking bench for quark_lsu with a bus responder and an
//            arithmetic reference model of lanes, extension and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quark_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_req;
   logic        core_we;
   logic [2:0]  core_funct3;
   logic [31:0] core_addr;
   logic [31:0] core_wdata;
   logic [31:0] core_rdata;
   logic        core_stall;
   logic        core_fault;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   quark_lsu #(.ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
      .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
      .core_stall(core_stall), .core_fault(core_fault),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata)
   );

   // Reference model
   function automatic bit m_is_byte(input logic [2:0] f);
      return (f == 3'd0) || (f == 3'd4);
   endfunction

   function automatic bit m_is_half(input logic [2:0] f);
      return (f == 3'd1) || (f == 3'd5);
   endfunction

   function automatic bit m_misaligned(input logic [2:0] f, input logic [1:0] off);
`ifdef QUARK_LSU_MISALIGN_TRAP_EN
      if (m_is_byte(f)) return 1'b0;
      if (m_is_half(f)) return (off % 2) != 0;
      return off != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f, input logic [1:0] off);
      if (m_is_byte(f)) return 4'b0001 << off;
      if (m_is_half(f)) return (off >= 2) ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] w);
      if (m_is_byte(f)) return (w & 32'hFF) * 32'h0101_0101;
      if (m_is_half(f)) return (w & 32'hFFFF) * 32'h0001_0001;
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f, input logic [1:0] off,
                                          input logic [31:0] word);
      logic [31:0] v;
      if (m_is_byte(f)) begin
         v = (word >> (8 * off)) & 32'hFF;
         if (f == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
         return v;
      end
      if (m_is_half(f)) begin
         v = (word >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
         if (f == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
         return v;
      end
      return word;
   endfunction

   // One core access against a responder granting after gdly waiting
   // REQ cycles and returning read data rdly cycles after the grant.
   task automatic do_access(input string name, input bit we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rword, input int gdly, input int rdly,
                            output logic [31:0] got_rdata, output int stalls);
      int  reqs = 0;
      int  since_gnt = 0;
      int  cyc = 0;
      int  exp_stalls;
      bit  granted = 1'b0;
      bit  done = 1'b0;
      bit  mis;
      logic        got_fault = 1'b0;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      logic [31:0] exp_rd;
      mis      = m_misaligned(f3, addr[1:0]);
      exp_addr = {addr[31:2], 2'b00};
      exp_be   = m_be(f3, addr[1:0]);
      exp_wd   = m_wdata(f3, wdata);
      exp_rd   = mis ? 32'd0 : m_load(f3, addr[1:0], rword);
      stalls   = 0;
      got_rdata = 32'd0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         core_req    = 1'b1;
         core_we     = we;
         core_funct3 = f3;
         core_addr   = addr;
         core_wdata  = wdata;
         bus_gnt     = 1'b0;
         bus_rvalid  = 1'b0;
         bus_rdata   = $urandom;
         if (bus_req) begin
            reqs++;
            n_vec++;
            if (bus_we !== we || bus_addr !== exp_addr || bus_be !== exp_be ||
                (we && bus_wdata !== exp_wd)) begin
               n_err++;
               $display("FAIL %s bus_fields: got we=%b addr=%h be=%b wdata=%h, want we=%b addr=%h be=%b wdata=%h",
                        name, bus_we, bus_addr, bus_be, bus_wdata, we, exp_addr, exp_be, exp_wd);
            end
            if (!granted && reqs == gdly + 1) begin
               bus_gnt   = 1'b1;
               granted   = 1'b1;
               since_gnt = 0;
            end
         end else if (granted) begin
            since_gnt++;
            if (!we && since_gnt == rdly) begin
               bus_rvalid = 1'b1;
               bus_rdata  = rword;
            end
         end
         #1;
         cyc++;
         if (core_stall) begin
            stalls++;
         end else begin
            done      = 1'b1;
            got_rdata = core_rdata;
            got_fault = core_fault;
         end
      end
      exp_stalls = mis ? 1 : (2 + gdly + (we ? 0 : rdly));
      n_vec++;
      if (!done || stalls != exp_stalls) begin
         n_err++;
         $display("FAIL %s stall_cycles: got %0d (done=%0d), want %0d", name, stalls, done, exp_stalls);
      end
      n_vec++;
      if (reqs != (mis ? 0 : gdly + 1)) begin
         n_err++;
         $display("FAIL %s bus_req_cycles: got %0d, want %0d", name, reqs, mis ? 0 : gdly + 1);
      end
      n_vec++;
      if (got_fault !== mis) begin
         n_err++;
         $display("FAIL %s core_fault: got %b, want %b", name, got_fault, mis);
      end
      if (!we || mis) begin
         n_vec++;
         if (got_rdata !== exp_rd) begin
            n_err++;
            $display("FAIL %s core_rdata: got %h, want %h", name, got_rdata, exp_rd);
         end
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         core_req   = 1'b0;
         bus_gnt    = 1'b0;
         bus_rvalid = 1'b0;
         #1;
         n_vec++;
         if (core_stall !== 1'b0 || bus_req !== 1'b0 || core_fault !== 1'b0) begin
            n_err++;
            $display("FAIL idle: got stall=%b req=%b fault=%b, want 0 0 0", core_stall, bus_req, core_fault);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; core_req = 1'b0; core_we = 1'b0; core_funct3 = 3'd0;
      core_addr = 32'd0; core_wdata = 32'd0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      n_vec++;
      if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, core_rdata, core_fault, core_stall} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wd=%h rd=%h fault=%b stall=%b, want all 0",
                  bus_req, bus_we, bus_addr, bus_be, bus_wdata, core_rdata, core_fault, core_stall);
      end
      idle_cycles(2);
   endtask

   task automatic test_directed();
      logic [31:0] rd;
      int st;
      do_access("sw_0x100", 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'd0, 0, 1, rd, st);
      n_vec++;
      if (st != 2) begin n_err++; $display("FAIL sw_stall: got %0d, want 2", st); end
      do_access("lb_0x103", 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_1234, 0, 1, rd, st);
      n_vec++;
      if (rd !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_value: got %h, want ffffff80", rd); end
      n_vec++;
      if (st != 3) begin n_err++; $display("FAIL lb_stall: got %0d, want 3", st); end
      do_access("lbu_0x103", 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF_1234, 0, 1, rd, st);
      n_vec++;
      if (rd !== 32'h0000_0080) begin n_err++; $display("FAIL lbu_value: got %h, want 00000080", rd); end
      do_access("sh_0x102", 1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 32'd0, 0, 1, rd, st);
      do_access("lhu_0x102", 1'b0, 3'b101, 32'h102, 32'd0, 32'hABCD_0000, 0, 1, rd, st);
      n_vec++;
      if (rd !== 32'h0000_ABCD) begin n_err++; $display("FAIL lhu_value: got %h, want 0000abcd", rd); end
      idle_cycles(1);
      do_access("lw_slow", 1'b0, 3'b010, 32'h2A4, 32'd0, 32'h1357_9BDF, 2, 2, rd, st);
      n_vec++;
      if (st != 6) begin n_err++; $display("FAIL lw_slow_stall: got %0d, want 6", st); end
      do_access("lh_neg", 1'b0, 3'b001, 32'h302, 32'd0, 32'h8001_7FFF, 1, 3, rd, st);
      n_vec++;
      if (rd !== 32'hFFFF_8001) begin n_err++; $display("FAIL lh_neg_value: got %h, want ffff8001", rd); end
      idle_cycles(1);
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      int st;
      int cyc = 0;
      bit seen = 1'b0;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         core_req = 1'b1; core_we = 1'b0; core_funct3 = 3'b010; core_addr = 32'h200;
         bus_gnt = 1'b0; bus_rvalid = 1'b0;
         if (bus_req) begin bus_gnt = 1'b1; seen = 1'b1; end
         cyc++;
      end
      @(negedge clk);
      bus_gnt = 1'b0; reset = 1'b1; core_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_vec++;
      if (!seen || bus_req !== 1'b0 || core_rdata !== 32'd0 || core_stall !== 1'b0) begin
         n_err++;
         $display("FAIL reset_in_wait: got seen=%0d req=%b rdata=%h stall=%b, want 1 0 0 0",
                  seen, bus_req, core_rdata, core_stall);
      end
      @(negedge clk);
      bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      bus_rvalid = 1'b0;
      #1;
      n_vec++;
      if (core_rdata !== 32'd0 || bus_req !== 1'b0) begin
         n_err++;
         $display("FAIL stray_rvalid: got rdata=%h req=%b, want 0 0", core_rdata, bus_req);
      end
      do_access("lbu_after_reset", 1'b0, 3'b100, 32'h201, 32'd0, 32'h0000_5A00, 0, 1, rd, st);
      n_vec++;
      if (rd !== 32'h0000_005A || st != 3) begin
         n_err++;
         $display("FAIL post_reset_load: got rdata=%h stall=%0d, want 0000005a 3", rd, st);
      end
   endtask

   task automatic test_misalign();
      logic [31:0] rd;
      int st;
      do_access("lw_0x101", 1'b0, 3'b010, 32'h101, 32'd0, 32'h1122_3344, 0, 1, rd, st);
`ifdef QUARK_LSU_MISALIGN_TRAP_EN
      n_vec++;
      if (st != 1 || rd !== 32'd0) begin
         n_err++;
         $display("FAIL misalign_trap: got stall=%0d rdata=%h, want 1 00000000", st, rd);
      end
      do_access("sh_0x103", 1'b1, 3'b001, 32'h103, 32'h1234, 32'd0, 0, 1, rd, st);
`else
      n_vec++;
      if (st != 3 || rd !== 32'h1122_3344) begin
         n_err++;
         $display("FAIL misalign_aligned: got stall=%0d rdata=%h, want 3 11223344", st, rd);
      end
`endif
      idle_cycles(1);
   endtask

   task automatic test_random();
      logic [31:0] rd;
      int st;
      for (int i = 0; i < 40; i++) begin
         do_access("random", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), rd, st);
         if ($urandom_range(0, 2) == 0) idle_cycles(1);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_mid();
      test_misalign();
      test_random();
      idle_cycles(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_quark_lsu
`default_nettype wire
